mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-cycle memory between a fetch port
// (read-only) and a data port (read/write). A round-robin grant on ties,
// a programmable number of idle wait states, then one ACCESS cycle.
// Optional feature: define MEM_ARB_ALIGN_CHECK_EN to reject odd byte
// addresses with an err_align pulse instead of touching memory.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [15:0]           if_rdata,
  output logic                  if_done,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic [15:0]           d_rdata,
  output logic                  d_done,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic                  busy
`ifdef MEM_ARB_ALIGN_CHECK_EN
  ,
  output logic                  err_align
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                  r_state, w_next;
  logic [3:0]              r_cnt;
  logic                    r_port;     // 1 = data port owns the transaction
  logic                    r_last_d;   // 1 = data port was granted last
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_wr;
  logic [15:0]             r_wdata;
  logic                    r_if_done, r_d_done;
  logic [15:0]             r_if_rdata, r_d_rdata;
  logic                    r_err;

  logic                    w_if_elig, w_d_elig, w_grant, w_grant_d, w_misalign;
  logic [ADDR_WIDTH-1:0]   w_gaddr;

  // A port that is pulsing done this cycle has not yet seen its request drop,
  // so it is excluded from arbitration for that cycle.
  assign w_if_elig = if_req & ~r_if_done;
  assign w_d_elig  = d_req  & ~r_d_done;
  assign w_grant   = w_if_elig | w_d_elig;
  assign w_grant_d = w_d_elig & (~w_if_elig | ~r_last_d);
  assign w_gaddr   = w_grant_d ? d_addr : if_addr;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign w_misalign = w_gaddr[0];
  assign err_align  = r_err;
`else
  assign w_misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: misaligned grants complete from IDLE without an access
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant && !w_misalign)
          w_next = (WAIT_INIT == 4'd0) ? S_ACCESS : S_WAIT;
      end
      S_WAIT:   if (r_cnt <= 4'd1) w_next = S_ACCESS;
      S_ACCESS: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs: memory is only enabled in ACCESS, write strobe gated by enable
  always_comb begin
    mem_enable = (r_state == S_ACCESS);
    mem_wr     = (r_state == S_ACCESS) & r_wr;
    mem_addr   = r_addr;
    mem_wdata  = r_wdata;
    busy       = (r_state != S_IDLE);
    if_done    = r_if_done;
    d_done     = r_d_done;
    if_rdata   = r_if_rdata;
    d_rdata    = r_d_rdata;
  end

  // Transaction latch, wait counter, completion pulses and read capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_port     <= 1'b0;
      r_last_d   <= 1'b0;
      r_addr     <= '0;
      r_wr       <= 1'b0;
      r_wdata    <= '0;
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_err     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_port   <= w_grant_d;
            r_last_d <= w_grant_d;
            r_addr   <= w_gaddr;
            r_wr     <= w_grant_d & d_wr;
            r_wdata  <= w_grant_d ? d_wdata : 16'h0000;
            r_cnt    <= WAIT_INIT;
            if (w_misalign) begin
              r_err <= 1'b1;
              if (w_grant_d) r_d_done  <= 1'b1;
              else           r_if_done <= 1'b1;
            end
          end
        end
        S_WAIT: r_cnt <= r_cnt - 4'd1;
        S_ACCESS: begin
          if (r_port) begin
            r_d_done <= 1'b1;
            if (!r_wr) r_d_rdata <= mem_rdata;
          end else begin
            r_if_done <= 1'b1;
            if (!r_wr) r_if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a schedule-based transaction model predicts
// every output each cycle for the WAIT_CYCLES=2 instance; a second instance
// with WAIT_CYCLES=0 is checked with directed literals.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A (WAIT_CYCLES = 2)
  logic        if_req = 0, d_req = 0, d_wr = 0;
  logic [15:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, d_done, mem_enable, mem_wr, busy;
  // instance B (WAIT_CYCLES = 0)
  logic        b_d_req = 0;
  logic [15:0] b_d_addr = 0;
  logic [15:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_if_done, b_d_done, b_mem_enable, b_mem_wr, b_busy;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic        err_align, b_err_align;
`endif

  mem_port_arbiter #(.ADDR_WIDTH(16), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_ALIGN_CHECK_EN
    , .err_align(err_align)
`endif
  );

  mem_port_arbiter #(.ADDR_WIDTH(16), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(16'h0000), .if_rdata(b_if_rdata), .if_done(b_if_done),
    .d_req(b_d_req), .d_wr(1'b0), .d_addr(b_d_addr), .d_wdata(16'h0000),
    .d_rdata(b_d_rdata), .d_done(b_d_done),
    .mem_enable(b_mem_enable), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
`ifdef MEM_ARB_ALIGN_CHECK_EN
    , .err_align(b_err_align)
`endif
  );

  function automatic logic [15:0] pre(input int i);
    return (i == 8) ? 16'h1234 : 16'(32'h1000 + i);
  endfunction

  int n_tests = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // memories seen by the DUTs (word addressed by addr[8:1])
  logic [15:0] mem [256];
  logic [15:0] memb [256];
  bit ld = 0, ldb = 0;
  assign mem_rdata   = mem[mem_addr[8:1]];
  assign b_mem_rdata = memb[b_mem_addr[8:1]];

  always @(posedge clk) begin
    if (!ld) begin
      for (int i = 0; i < 256; i++) mem[i] <= pre(i);
      ld <= 1;
    end else if (mem_enable && mem_wr) mem[mem_addr[8:1]] <= mem_wdata;
  end

  always @(posedge clk) begin
    if (!ldb) begin
      for (int i = 0; i < 256; i++) memb[i] <= pre(i);
      ldb <= 1;
    end else if (b_mem_enable && b_mem_wr) memb[b_mem_addr[8:1]] <= b_mem_wdata;
  end

  // ---------------- transaction model ----------------
  // Cycle k is the interval following the k-th rising edge. A grant at the
  // edge closing cycle c puts the access in cycle c+1+W and done in c+2+W.
  bit          m_on = 0, m_ld = 0;
  int          m_free = 0, m_acc = -1, m_done = -1, m_err = -1;
  logic        m_dport = 0, m_gport = 0, m_last_d = 0, m_wr = 0;
  logic [15:0] m_addr = 0, m_wdata = 0, m_ifr = 0, m_dr = 0;
  logic [15:0] m_mem [256];
  logic        t_ie, t_de, t_g;
  logic [15:0] t_ga;

  assign t_ie = if_req && !(m_done == cyc && !m_dport);
  assign t_de = d_req  && !(m_done == cyc &&  m_dport);
  assign t_g  = t_de && (!t_ie || !m_last_d);
  assign t_ga = t_g ? d_addr : if_addr;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!m_ld) begin
      for (int i = 0; i < 256; i++) m_mem[i] <= pre(i);
      m_ld <= 1;
    end else if (m_acc == cyc && m_wr) m_mem[m_addr[8:1]] <= m_wdata;
    if (rst) begin
      m_on <= 1; m_free <= cyc + 1; m_acc <= -1; m_done <= -1; m_err <= -1;
      m_last_d <= 0; m_ifr <= 0; m_dr <= 0;
    end else if (m_on) begin
      if (m_acc == cyc) begin
        m_done <= cyc + 1; m_dport <= m_gport;
        if (!m_wr) begin
          if (m_gport) m_dr  <= m_mem[m_addr[8:1]];
          else         m_ifr <= m_mem[m_addr[8:1]];
        end
      end
      if (cyc >= m_free && (t_ie || t_de)) begin
        m_last_d <= t_g; m_gport <= t_g; m_addr <= t_ga;
        m_wr <= t_g & d_wr; m_wdata <= d_wdata;
        if (ALIGN && t_ga[0]) begin
          m_done <= cyc + 1; m_dport <= t_g; m_err <= cyc + 1; m_free <= cyc + 1;
        end else begin
          m_acc <= cyc + 1 + W; m_free <= cyc + 2 + W;
        end
      end
    end
  end

  // ---------------- compare + event log ----------------
  int          en_cnt = 0, en_cyc = -1, ifd_cyc = -1, dd_cyc = -1, dd_cnt = 0;
  int          wr20 = 0, err_cyc = -1, ord_n = 0;
  logic [15:0] en_addr = 0;
  logic [1:0]  ord [16];
  int          b_en_cnt = 0, b_en_cyc = -1, b_dd_cyc = -1;

  always @(negedge clk) begin
    if (m_on) begin
      chk("mem_enable", mem_enable, cyc == m_acc);
      chk("mem_wr", mem_wr, (cyc == m_acc) && m_wr);
      if (cyc == m_acc) begin
        chk("mem_addr", mem_addr, m_addr);
        if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("if_done", if_done, cyc == m_done && !m_dport);
      chk("d_done", d_done, cyc == m_done && m_dport);
      chk("busy", busy, cyc < m_free);
      chk("if_rdata", if_rdata, m_ifr);
      chk("d_rdata", d_rdata, m_dr);
`ifdef MEM_ARB_ALIGN_CHECK_EN
      chk("err_align", err_align, cyc == m_err);
      if (err_align === 1'b1) err_cyc <= cyc;
`endif
      if (mem_enable === 1'b1) begin
        en_cnt <= en_cnt + 1; en_cyc <= cyc; en_addr <= mem_addr;
        if (mem_wr === 1'b1 && mem_addr == 16'h0020) wr20 <= wr20 + 1;
      end
      if (if_done === 1'b1) begin
        ifd_cyc <= cyc;
        if (ord_n < 16) begin ord[ord_n] <= 2'd1; ord_n <= ord_n + 1; end
      end else if (d_done === 1'b1) begin
        if (ord_n < 16) begin ord[ord_n] <= 2'd2; ord_n <= ord_n + 1; end
      end
      if (d_done === 1'b1) begin dd_cyc <= cyc; dd_cnt <= dd_cnt + 1; end
      if (b_mem_enable === 1'b1) begin b_en_cnt <= b_en_cnt + 1; b_en_cyc <= cyc; end
      if (b_d_done === 1'b1) b_dd_cyc <= cyc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic run_if(input logic [15:0] a, output int r);
    bit got = 0;
    if_addr = a; if_req = 1; r = cyc;
    for (int k = 0; k < 40 && !got; k++) begin tick(); got = (if_done === 1'b1); end
    chk("if_done_timeout", got, 1);
    if_req = 0;
    tick();
  endtask

  task automatic run_d(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                       output int r);
    bit got = 0;
    d_wr = wr; d_addr = a; d_wdata = wd; d_req = 1; r = cyc;
    for (int k = 0; k < 40 && !got; k++) begin tick(); got = (d_done === 1'b1); end
    chk("d_done_timeout", got, 1);
    d_req = 0; d_wr = 0;
    tick();
  endtask

  initial begin
    int r, r1, r2, e0, dd0, base, bad;
    logic [15:0] keep;
    bit got;
    rst = 1;
    repeat (3) tick();
    rst = 0;
    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_done", d_done, 0);

    // simultaneous requests from reset: data wins the first tie
    base = ord_n;
    fork
      begin run_if(16'h0100, r1); run_if(16'h0102, r1); end
      begin run_d(0, 16'h0104, 0, r2); run_d(0, 16'h0106, 0, r2); end
    join
    chk("rr_order0", ord[base],   2);
    chk("rr_order1", ord[base+1], 1);
    chk("rr_order2", ord[base+2], 2);
    chk("rr_order3", ord[base+3], 1);
    chk("rr_if_rdata", if_rdata, 16'h1081);
    chk("rr_d_rdata", d_rdata, 16'h1083);

    // basic fetch latency
    e0 = en_cnt;
    run_if(16'h0010, r);
    chk("lat_en_cyc", en_cyc, r + 3);
    chk("lat_done_cyc", ifd_cyc, r + 4);
    chk("lat_en_once", en_cnt - e0, 1);
    chk("lat_rdata", if_rdata, 16'h1234);

    // write then read back through the other port
    run_d(1, 16'h0020, 16'hBEEF, r);
    run_if(16'h0020, r);
    chk("wr_rd_data", if_rdata, 16'hBEEF);
    chk("wr_once", wr20, 1);
    chk("wr_mem", mem[16], 16'hBEEF);

    // tie after a data grant goes to fetch
    run_d(0, 16'h0002, 0, r);
    chk("d_read", d_rdata, 16'h1001);
    base = ord_n;
    fork
      run_if(16'h0004, r1);
      run_d(0, 16'h0006, 0, r2);
    join
    chk("tie_first_fetch", ord[base], 1);
    chk("tie_then_data", ord[base+1], 2);
    chk("tie_d_rdata", d_rdata, 16'h1003);

    // odd address
    keep = d_rdata; e0 = en_cnt;
    run_d(0, 16'h0031, 0, r);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    chk("align_err_cyc", err_cyc, r + 1);
    chk("align_done_cyc", dd_cyc, r + 1);
    chk("align_no_access", en_cnt - e0, 0);
    chk("align_rdata_kept", d_rdata, keep);
`else
    chk("odd_done_cyc", dd_cyc, r + 4);
    chk("odd_addr_bit0", en_addr, 16'h0031);
    chk("odd_rdata", d_rdata, 16'h1018);
`endif

    // reset while a write waits: nothing reaches memory
    e0 = en_cnt; dd0 = dd_cnt;
    d_wr = 1; d_addr = 16'h0040; d_wdata = 16'hAAAA; d_req = 1;
    tick();
    rst = 1; d_req = 0; d_wr = 0;
    tick();
    rst = 0;
    repeat (6) tick();
    chk("abort_no_enable", en_cnt - e0, 0);
    chk("abort_no_done", dd_cnt - dd0, 0);
    chk("abort_mem", mem[32], 16'h1020);
    chk("abort_idle", busy, 0);

    // zero wait states on instance B
    b_d_addr = 16'h0008; b_d_req = 1; r = cyc; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin tick(); got = (b_d_done === 1'b1); end
    chk("b_done_timeout", got, 1);
    b_d_req = 0;
    tick();
    chk("b_en_cyc", b_en_cyc, r + 1);
    chk("b_done_cyc", b_dd_cyc, r + 2);
    chk("b_rdata", b_d_rdata, 16'h1004);
    chk("b_en_once", b_en_cnt, 1);

    // final memory image matches the model
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) bad++;
    chk("mem_image", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
